// File: rtl/harvos_dmem_arbiter.sv
// Two-master round-robin arbiter for the HarvOS data-memory port.
// One transaction in flight; registered slave request with a watchdog abort.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction in flight; a requesting master is granted on the edge
// BUSY  | s_req high; waiting for slave done/fault or watchdog expiry
module harvos_dmem_arbiter #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 9
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    output logic        m0_fault,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic        m1_fault,

    output logic        s_req,
    output logic        s_we,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_done,
    input  logic        s_fault,

    output logic        busy_o,
    output logic        owner_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // The watchdog is a down-counter loaded at grant; reaching zero while still
    // BUSY marks the TIMEOUT-th cycle without a slave response.
    localparam bit               WDOG_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WDOG_LOAD = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;   // master preferred on the next tie
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;

    logic any_req;
    logic winner;
    logic grant;
    logic done_hit;
    logic fault_hit;
    logic wdog_expired;
    logic busy;

    assign any_req      = m0_req | m1_req;
    assign winner       = (m0_req & m1_req) ? rr_ptr_q : m1_req;
    assign busy         = (state_q == ST_BUSY);
    assign wdog_expired = WDOG_EN && (wdog_q == '0);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        wdog_d    = wdog_q;
        grant     = 1'b0;
        done_hit  = 1'b0;
        fault_hit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant   = 1'b1;
                    owner_d = winner;
                    wdog_d  = WDOG_LOAD;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A slave fault beats done; a slave response beats the watchdog.
                if (s_fault) begin
                    fault_hit = 1'b1;
                end else if (s_done) begin
                    done_hit = 1'b1;
                end else if (wdog_expired) begin
                    fault_hit = 1'b1;
                end

                if (done_hit || fault_hit) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = ~owner_q;
                end else if (wdog_q != '0) begin
                    wdog_d = wdog_q - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= 1'b0;
            owner_q  <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            wdog_q   <= wdog_d;
        end
    end

    // Downstream command is captured once at grant and held until the next grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_we    <= 1'b0;
            s_be    <= 4'h0;
            s_addr  <= 32'h0;
            s_wdata <= 32'h0;
        end else if (grant) begin
            s_we    <= winner ? m1_we    : m0_we;
            s_be    <= winner ? m1_be    : m0_be;
            s_addr  <= winner ? m1_addr  : m0_addr;
            s_wdata <= winner ? m1_wdata : m0_wdata;
        end
    end

    assign s_req   = busy;
    assign busy_o  = busy;
    assign owner_o = owner_q;

    assign m0_done  = done_hit  & ~owner_q;
    assign m1_done  = done_hit  &  owner_q;
    assign m0_fault = fault_hit & ~owner_q;
    assign m1_fault = fault_hit &  owner_q;
    assign m0_rdata = m0_done ? s_rdata : 32'h0;
    assign m1_rdata = m1_done ? s_rdata : 32'h0;

endmodule

// File: tb/tb_harvos_dmem_arbiter.sv
// Bench for harvos_dmem_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_harvos_dmem_arbiter;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [3:0]  m0_be = 0, m1_be = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_done, m0_fault, m1_done, m1_fault;
    logic        s_req, s_we;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata;
    logic [31:0] s_rdata = 0;
    logic        s_done = 0, s_fault = 0;
    logic        busy_o, owner_o;

    harvos_dmem_arbiter #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_fault(m0_fault),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_fault(m1_fault),
        .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_done(s_done), .s_fault(s_fault),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: the transaction in flight (if any) and who is preferred on a tie.
    bit          md_busy, md_owner, md_pref;
    int          md_age;               // BUSY cycles already elapsed
    logic        md_we;
    logic [3:0]  md_be;
    logic [31:0] md_addr, md_wdata;
    bit   [1:0]  ev_done, ev_fault;    // result pulses of the last compared cycle

    // Slave behaviour for the current transaction: respond after sl_wait BUSY
    // cycles with kind 0=done 1=fault 2=done+fault 3=never.
    int  sl_wait, sl_kind;
    bit  dir_mode = 1, auto_mode = 0, dir_rd_en = 0;
    int  dir_wait = 0, dir_kind = 0;
    logic [31:0] dir_rdata = 0;

    int grant_log[$];
    int owner_log[$];
    int cnt_sreq, cnt_m0_done, cnt_m0_fault, cnt_m1_done, cnt_m1_any, cnt_fwd, sreq_at_fault;
    logic [31:0] cap_rdata;
    logic obs_sreq, obs_busy;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        md_busy = 0; md_owner = 0; md_pref = 0; md_age = 0;
        md_we = 0; md_be = 0; md_addr = 0; md_wdata = 0;
        ev_done = 0; ev_fault = 0;
    endtask

    task automatic clr_obs();
        cnt_sreq = 0; cnt_m0_done = 0; cnt_m0_fault = 0; cnt_m1_done = 0;
        cnt_m1_any = 0; cnt_fwd = 0; sreq_at_fault = 0; cap_rdata = 0;
        grant_log.delete(); owner_log.delete();
    endtask

    task automatic pick_slave_plan();
        if (dir_mode) begin
            sl_wait = dir_wait; sl_kind = dir_kind;
        end else begin
            int r;
            r = $urandom_range(0, 15);
            sl_kind = (r <= 10) ? 0 : (r <= 12) ? 1 : (r == 13) ? 2 : 3;
            sl_wait = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 2);
        end
    endtask

    // Compare the DUT against the model for the current cycle, then advance the model.
    task automatic model_step();
        bit end_ok, end_f, win;
        end_ok = md_busy && s_done && !s_fault;
        end_f  = md_busy && (s_fault || (md_age == TO - 1 && !s_done));
        ev_done = 0; ev_fault = 0;
        if (end_ok) ev_done[md_owner] = 1'b1;
        if (end_f)  ev_fault[md_owner] = 1'b1;

        chk("s_req", s_req, md_busy);
        chk("busy_o", busy_o, md_busy);
        chk("owner_o", owner_o, md_owner);
        chk("s_cmd", {s_we, s_be, s_addr, s_wdata}, {md_we, md_be, md_addr, md_wdata});
        chk("m0_done", m0_done, ev_done[0]);
        chk("m1_done", m1_done, ev_done[1]);
        chk("m0_fault", m0_fault, ev_fault[0]);
        chk("m1_fault", m1_fault, ev_fault[1]);
        chk("m0_rdata", m0_rdata, ev_done[0] ? s_rdata : 32'h0);
        chk("m1_rdata", m1_rdata, ev_done[1] ? s_rdata : 32'h0);

        if (md_busy) begin
            if (end_ok || end_f) md_busy = 0;
            else md_age++;
        end else if (m0_req || m1_req) begin
            win = (m0_req && m1_req) ? md_pref : m1_req;
            md_busy = 1; md_owner = win; md_age = 0; md_pref = !win;
            md_we    = win ? m1_we    : m0_we;
            md_be    = win ? m1_be    : m0_be;
            md_addr  = win ? m1_addr  : m0_addr;
            md_wdata = win ? m1_wdata : m0_wdata;
            grant_log.push_back(int'(win));
            pick_slave_plan();
        end
    endtask

    task automatic drive_slave();
        s_done = 0; s_fault = 0; s_rdata = $urandom;
        if (md_busy && md_age == sl_wait && sl_kind != 3) begin
            s_done  = (sl_kind == 0 || sl_kind == 2);
            s_fault = (sl_kind == 1 || sl_kind == 2);
            if (dir_rd_en) s_rdata = dir_rdata;
        end
    endtask

    task automatic rand_m(input int k);
        if (k == 0) begin
            m0_req = 1; m0_we = 1'($urandom); m0_be = 4'($urandom);
            m0_addr = $urandom; m0_wdata = $urandom;
        end else begin
            m1_req = 1; m1_we = 1'($urandom); m1_be = 4'($urandom);
            m1_addr = $urandom; m1_wdata = $urandom;
        end
    endtask

    task automatic drive_masters();
        if (ev_done[0] || ev_fault[0]) begin
            if ($urandom_range(0, 1) == 1) rand_m(0); else m0_req = 0;
        end else if (!m0_req && $urandom_range(0, 2) == 0) rand_m(0);
        if (ev_done[1] || ev_fault[1]) begin
            if ($urandom_range(0, 1) == 1) rand_m(1); else m1_req = 0;
        end else if (!m1_req && $urandom_range(0, 2) == 0) rand_m(1);
    endtask

    // Entered and left just after a rising edge; outputs sampled on the falling edge.
    task automatic cycle();
        @(negedge clk_i);
        cyc++;
        obs_sreq = s_req; obs_busy = busy_o;
        if (s_req) cnt_sreq++;
        if (m0_done) begin cnt_m0_done++; cap_rdata = m0_rdata; end
        if (m0_fault) begin cnt_m0_fault++; sreq_at_fault = cnt_sreq; end
        if (m1_done) cnt_m1_done++;
        if (m1_done || m1_fault || m1_rdata != 0) cnt_m1_any++;
        if (s_req && s_we && s_be == 4'b0011 && s_addr == 32'h20 && s_wdata == 32'h1234_5678) cnt_fwd++;
        if (m0_done || m0_fault || m1_done || m1_fault) owner_log.push_back(int'(owner_o));
        model_step();
        @(posedge clk_i);
        #1;
        drive_slave();
        if (auto_mode) drive_masters();
    endtask

    task automatic run_to_end(input int k, input int budget, input string nm);
        bit got;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            cycle();
            if (ev_done[k] || ev_fault[k]) got = 1;
        end
        chk({nm, "_completed"}, got, 1);
    endtask

    task automatic set_m0(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        m0_we = we; m0_be = be; m0_addr = a; m0_wdata = d; m0_req = 1;
    endtask

    task automatic set_m1(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        m1_we = we; m1_be = be; m1_addr = a; m1_wdata = d; m1_req = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "bench timeout");
    end

    initial begin
        int n0, n1;
        model_reset();
        clr_obs();
        #1 rst_ni = 0;
        #1;
        chk("reset_ctrl", {s_req, busy_o, owner_o, s_we, s_be}, 0);
        chk("reset_cmd", {s_addr, s_wdata}, 0);
        chk("reset_master", {m0_done, m0_fault, m1_done, m1_fault, m0_rdata, m1_rdata}, 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1;
        @(posedge clk_i);
        #1;

        // Contention from reset: both masters hold req for 4 transactions each.
        clr_obs();
        dir_wait = 0; dir_kind = 0;
        set_m0(0, 4'hF, 32'h100, 32'h0);
        set_m1(0, 4'hF, 32'h200, 32'h0);
        n0 = 0; n1 = 0;
        for (int i = 0; i < 80 && (n0 < 4 || n1 < 4); i++) begin
            cycle();
            if (ev_done[0]) begin n0++; if (n0 == 4) m0_req = 0; end
            if (ev_done[1]) begin n1++; if (n1 == 4) m1_req = 0; end
        end
        chk("contention_m0_count", n0, 4);
        chk("contention_m1_count", n1, 4);
        chk("contention_grants", grant_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            int g, o;
            g = (i < grant_log.size()) ? grant_log[i] : 9;
            o = (i < owner_log.size()) ? owner_log[i] : 9;
            chk($sformatf("contention_grant%0d", i), g, i % 2);
            chk($sformatf("contention_owner%0d", i), o, i % 2);
        end
        repeat (2) cycle();

        // Single read, slave answers two cycles after s_req rises.
        clr_obs();
        dir_wait = 2; dir_kind = 0; dir_rd_en = 1; dir_rdata = 32'hDEAD_BEEF;
        set_m0(0, 4'hF, 32'h0000_1000, 32'h0);
        run_to_end(0, 20, "single_read");
        m0_req = 0;
        repeat (2) cycle();
        dir_rd_en = 0;
        chk("single_read_done_pulses", cnt_m0_done, 1);
        chk("single_read_rdata", cap_rdata, 32'hDEAD_BEEF);
        chk("single_read_sreq_cycles", cnt_sreq, 3);
        chk("single_read_m1_quiet", cnt_m1_any, 0);

        // Write forwarding from master 1.
        clr_obs();
        dir_wait = 3; dir_kind = 0;
        set_m1(1, 4'b0011, 32'h20, 32'h1234_5678);
        run_to_end(1, 20, "write_fwd");
        m1_req = 0;
        cycle();
        chk("write_fwd_stable_cycles", cnt_fwd, 4);
        chk("write_fwd_sreq_cycles", cnt_sreq, 4);
        chk("write_fwd_done", cnt_m1_done, 1);

        // Slave asserts done and fault together.
        clr_obs();
        dir_wait = 1; dir_kind = 2;
        set_m0(0, 4'h1, 32'h44, 32'h0);
        run_to_end(0, 20, "fault_done");
        m0_req = 0;
        cycle();
        chk("fault_done_fault", cnt_m0_fault, 1);
        chk("fault_done_no_done", cnt_m0_done, 0);
        chk("fault_done_idle", obs_busy, 0);

        // Hung slave: watchdog fault on the 8th BUSY cycle.
        clr_obs();
        dir_kind = 3; dir_wait = 0;
        set_m0(0, 4'hF, 32'h80, 32'h0);
        run_to_end(0, 30, "watchdog");
        m0_req = 0;
        cycle();
        chk("watchdog_fault", cnt_m0_fault, 1);
        chk("watchdog_fault_cycle", sreq_at_fault, 8);
        chk("watchdog_sreq_low_after", obs_sreq, 0);
        chk("watchdog_no_done", cnt_m0_done, 0);

        // Slave done in that same 8th cycle wins over the watchdog.
        clr_obs();
        dir_kind = 0; dir_wait = 7;
        set_m0(0, 4'hF, 32'h84, 32'h0);
        run_to_end(0, 30, "watchdog_race");
        m0_req = 0;
        cycle();
        chk("watchdog_race_done", cnt_m0_done, 1);
        chk("watchdog_race_no_fault", cnt_m0_fault, 0);
        chk("watchdog_race_sreq_cycles", cnt_sreq, 8);

        // Reset mid-BUSY, then a master-1-only request.
        clr_obs();
        dir_kind = 3;
        set_m1(1, 4'hC, 32'h40, 32'hA5A5_0001);
        repeat (4) cycle();
        chk("rstmid_busy_before", obs_busy, 1);
        #2 rst_ni = 0;
        m1_req = 0; s_done = 0; s_fault = 0;
        #1;
        chk("rstmid_async_ctrl", {s_req, busy_o, owner_o, s_we, s_be}, 0);
        chk("rstmid_async_cmd", {s_addr, s_wdata}, 0);
        chk("rstmid_async_master", {m0_done, m0_fault, m1_done, m1_fault, m0_rdata, m1_rdata}, 0);
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        chk("rstmid_held_master", {m0_done, m0_fault, m1_done, m1_fault, s_req}, 0);
        @(negedge clk_i) rst_ni = 1;
        model_reset();
        @(posedge clk_i);
        #1;
        clr_obs();
        dir_kind = 0; dir_wait = 1;
        set_m1(0, 4'hF, 32'h60, 32'h0);
        run_to_end(1, 20, "rstmid_after");
        m1_req = 0;
        cycle();
        chk("rstmid_after_m1_done", cnt_m1_done, 1);
        chk("rstmid_after_owner", (owner_log.size() > 0) ? owner_log[0] : 9, 1);

        // Random traffic against the model.
        dir_mode = 0;
        auto_mode = 1;
        repeat (2500) cycle();
        auto_mode = 0;
        m0_req = 0; m1_req = 0;
        repeat (20) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
